// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline: load enables, injected valid bits, counters, stall watchdog.
// Latency: enables/valids are combinational (0 cycles); state, counters and stall_timeout update on the next edge.
module pipeline_control #(
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_imem_read,
    input  logic                 imem_resp,
    input  logic                 mem_valid,
    input  logic                 mem_dmem_req,
    input  logic                 dmem_resp,
    input  logic                 br_taken,
    input  logic                 ex_valid,
    input  logic                 ex_is_load,
    input  logic [2:0]           ex_dest,
    input  logic [2:0]           de_sr1,
    input  logic [2:0]           de_sr2,
    input  logic                 de_uses_sr1,
    input  logic                 de_uses_sr2,
    input  logic                 de_valid,
    output logic                 load_pc,
    output logic                 load_de,
    output logic                 load_ex,
    output logic                 load_mem,
    output logic                 load_wb,
    output logic                 de_valid_in,
    output logic                 ex_valid_in,
    output logic                 mem_valid_in,
    output logic                 wb_valid_in,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic                 stall_timeout
);

    typedef enum logic [1:0] {RUN = 2'd0, DSTALL = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [15:0]          WD_LIMIT = 16'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [15:0]          wd_q, wd_d;
    logic                 timeout_q, timeout_d;

    logic dstall, flush_req, flush_act, luse_raw, luse, istall, stall_cyc;

    always_comb begin
        dstall    = mem_valid & mem_dmem_req & ~dmem_resp;
        flush_req = mem_valid & br_taken;
        luse_raw  = ex_valid & ex_is_load & de_valid &
                    ((de_uses_sr1 & (de_sr1 == ex_dest)) | (de_uses_sr2 & (de_sr2 == ex_dest)));
        // The cycle after a flush DE/EX hold bubbles, so a load-use match there is stale.
        luse      = luse_raw & (state_q != FLUSH);
        istall    = if_imem_read & ~imem_resp;
        flush_act = flush_req & ~dstall;
        stall_cyc = (dstall | luse | istall) & ~flush_act;
    end

    always_comb begin
        load_pc      = 1'b1;
        load_de      = 1'b1;
        load_ex      = 1'b1;
        load_mem     = 1'b1;
        load_wb      = 1'b1;
        de_valid_in  = 1'b1;
        ex_valid_in  = de_valid;
        mem_valid_in = ex_valid;
        wb_valid_in  = mem_valid;
        if (reset) begin
            load_pc      = 1'b0;
            load_de      = 1'b0;
            load_ex      = 1'b0;
            load_mem     = 1'b0;
            load_wb      = 1'b0;
            de_valid_in  = 1'b0;
            ex_valid_in  = 1'b0;
            mem_valid_in = 1'b0;
            wb_valid_in  = 1'b0;
        end else if (dstall) begin
            load_pc     = 1'b0;
            load_de     = 1'b0;
            load_ex     = 1'b0;
            load_mem    = 1'b0;
            wb_valid_in = 1'b0;
        end else if (flush_act) begin
            de_valid_in  = 1'b0;
            ex_valid_in  = 1'b0;
            mem_valid_in = 1'b0;
        end else if (luse) begin
            load_pc     = 1'b0;
            load_de     = 1'b0;
            ex_valid_in = 1'b0;
        end else if (istall) begin
            load_pc     = 1'b0;
            de_valid_in = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, FLUSH: begin
                if (dstall)         state_d = DSTALL;
                else if (flush_act) state_d = FLUSH;
                else                state_d = RUN;
            end
            DSTALL: begin
                if (!dstall) state_d = flush_act ? FLUSH : RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_cyc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush_act && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
        // Watchdog parks at its limit; the sticky flag fires once dstall persists beyond it.
        wd_d      = dstall ? ((wd_q == WD_LIMIT) ? wd_q : wd_q + 16'd1) : 16'd0;
        timeout_d = timeout_q | (dstall & (wd_q == WD_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wd_q        <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
        end
    end

    assign state         = state_q;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;
    assign stall_timeout = timeout_q;

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Central stall/flush sequencer for the 5-stage LC-3b pipeline. Generates the load enables for the PC and the IF/DE, DE/EX, EX/MEM and MEM/WB pipeline registers, and the valid bit injected into each register. Resolves memory-wait freezes, load-use hazards, instruction-fetch misses and taken-branch flushes with fixed priority. Keeps saturating stall/flush counters and a stall watchdog.

Parameters:
TIMEOUT, 64, max consecutive DSTALL cycles before stall_timeout sets (1..65535)
CNT_WIDTH, 16, width of stall_count/flush_count

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
if_imem_read  in  1  IF stage requesting instruction memory
imem_resp  in  1  instruction memory response this cycle
mem_valid  in  1  valid bit of instruction in MEM stage
mem_dmem_req  in  1  MEM-stage instruction accesses data memory
dmem_resp  in  1  data memory response this cycle
br_taken  in  1  branch/jump resolved taken in MEM stage
ex_valid  in  1  valid bit of EX-stage instruction
ex_is_load  in  1  EX-stage instruction is LDR/LDB/LDI
ex_dest  in  3  EX-stage destination register
de_sr1, de_sr2  in  3 each  DE-stage source registers
de_uses_sr1, de_uses_sr2  in  1 each  DE instruction reads that source
de_valid  in  1  valid bit of DE-stage instruction
load_pc, load_de, load_ex, load_mem, load_wb  out  1 each  register load enables
de_valid_in, ex_valid_in, mem_valid_in, wb_valid_in  out  1 each  valid bit written into DE/EX/MEM/WB registers
state  out  2  RUN=0, DSTALL=1, FLUSH=2
stall_count  out  CNT_WIDTH  saturating count of stall cycles
flush_count  out  CNT_WIDTH  saturating count of flushes
stall_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (sampled on clk edge): state=RUN, counters=0, stall_timeout=0, watchdog counter=0. While reset is high, all load_* and *_valid_in outputs are forced 0.
- Derived terms: dstall = mem_valid & mem_dmem_req & ~dmem_resp. flush = mem_valid & br_taken. luse = ex_valid & ex_is_load & de_valid & ((de_uses_sr1 & de_sr1==ex_dest) | (de_uses_sr2 & de_sr2==ex_dest)). istall = if_imem_read & ~imem_resp.
- Priority, evaluated combinationally each cycle: dstall > flush > luse > istall > normal.
- dstall: load_pc=load_de=load_ex=load_mem=0; load_wb=1, wb_valid_in=0, so a bubble enters WB and MEM holds.
- flush: all loads=1 (PC takes target). de_valid_in=ex_valid_in=mem_valid_in=0. wb_valid_in=mem_valid. Overrides a simultaneous luse/istall; the wrong-path fetch is discarded.
- luse: load_pc=load_de=0. load_ex=load_mem=load_wb=1. ex_valid_in=0; other valid_in pass upstream valid.
- istall: load_pc=0, all other loads=1, de_valid_in=0.
- normal: all loads=1. de_valid_in=1. ex_valid_in=de_valid, mem_valid_in=ex_valid, wb_valid_in=mem_valid.
- FSM, registered:
  - RUN: dstall->DSTALL; flush->FLUSH; else RUN.
  - DSTALL: dmem_resp->RUN; else stay. On the resp cycle dstall=0, so the pipe advances that same cycle.
  - FLUSH: lasts one cycle. In FLUSH, luse is ignored because DE/EX hold bubbles. Next state is DSTALL if dstall, else RUN; a new flush re-enters FLUSH.
- Watchdog: counts consecutive cycles with dstall=1 and clears when dstall=0. When the count reaches TIMEOUT and dstall is still 1, stall_timeout sets the next edge. stall_timeout stays set until reset. Pipeline behaviour is unaffected.
- stall_count: +1 on each cycle with dstall|luse|istall (one increment even if several are true), unless it is a flush cycle.
- flush_count: +1 per flush cycle.
- Both counters saturate at all-ones and never wrap.
- All outputs except state, counters and stall_timeout are combinational: zero-cycle latency from inputs.

Test Plan:
1. Hold reset 2 cycles with dstall, flush and luse inputs active -> all load_*/valid_in=0, state=0, counters=0; after release with idle inputs -> all loads=1, de_valid_in=1.
2. ex_valid=1, ex_is_load=1, ex_dest=3, de_valid=1, de_sr1=3, de_uses_sr1=1 -> load_pc=0, load_de=0, load_ex=1, ex_valid_in=0, stall_count=1. Repeat with de_uses_sr1=0 -> no stall.
3. mem_valid=1, mem_dmem_req=1, dmem_resp low 5 cycles then high -> state=DSTALL for 5 cycles; loads 0 except load_wb=1 with wb_valid_in=0; stall_count=5; resp cycle all loads=1, state returns to RUN.
4. flush with istall and luse in the same cycle -> load_pc=1, de/ex/mem_valid_in=0, flush_count=1, stall_count unchanged, state=FLUSH for 1 cycle.
5. TIMEOUT=8, dmem_resp never asserted -> stall_timeout=0 through 8 stall cycles, 1 from the 9th edge onward; stays 1 after dstall drops; clears only on reset.
6. Hold istall for 70000 cycles -> stall_count saturates at 0xFFFF and stays there.
